// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared definitions for the instruction-fetch stage.
//   - BUBBLE_INST_DEF: NOP word presented when no valid instruction exists
//                      (same encoding IF/ID inserts on flush)
//   - ST_*: 2-bit fetch FSM state encodings
//   - OPCODE_W / JFIELD_W: instruction field widths shared with IF/ID
//   - jump_target(): J-type target from PC+4 and the 26-bit field
package if_fetch_pkg;

  localparam logic [31:0] BUBBLE_INST_DEF = 32'hFC00_0000;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned JFIELD_W = 32 - OPCODE_W;

  localparam logic [1:0] ST_REQ     = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  // Upper nibble of PC+4 is kept, field is word-aligned below it.
  function automatic logic [31:0] jump_target(input logic [31:0]         pc4,
                                               input logic [JFIELD_W-1:0] field);
    return (pc4 & 32'hF000_0000) | {4'b0000, field, 2'b00};
  endfunction

endpackage

// File: rtl/if_next_pc.sv
// if_next_pc: combinational next-PC logic for the fetch stage.
//   i_pc            current program counter
//   i_hd            hazard stall, masks redirects
//   i_branch        taken branch (priority over jump)
//   i_branch_addr   branch target, low two bits ignored
//   i_jump          jump resolved in ID
//   i_jump_field    instr[25:0] of the jump
//   i_jump_pc4      PC+4 of the jump instruction
//   o_redirect      redirect the fetch stream this cycle
//   o_target        redirect target address
//   o_pc4           i_pc + 4 (wraps modulo 2^32)
module if_next_pc
  import if_fetch_pkg::*;
(
  input  logic [31:0]         i_pc,
  input  logic                i_hd,
  input  logic                i_branch,
  input  logic [31:0]         i_branch_addr,
  input  logic                i_jump,
  input  logic [JFIELD_W-1:0] i_jump_field,
  input  logic [31:0]         i_jump_pc4,
  output logic                o_redirect,
  output logic [31:0]         o_target,
  output logic [31:0]         o_pc4
);

  assign o_redirect = (i_branch | i_jump) & ~i_hd;
  assign o_target   = i_branch ? (i_branch_addr & 32'hFFFF_FFFC)
                               : jump_target(i_jump_pc4, i_jump_field);
  assign o_pc4      = i_pc + 32'd4;

endmodule

// File: rtl/if_fetch.sv
// if_fetch: MIPS instruction-fetch stage feeding the IF/ID register.
// Owns the PC, issues requests to a variable-latency instruction memory,
// absorbs load-use stalls and applies branch/jump redirects from ID.
//   clk_i, rst_i          clock, synchronous active-high reset
//   hd_i                  hazard stall (IF/ID holds)
//   branch_i/branch_addr_i, jump_i/jump_field_i/jump_pc4_i  redirects from ID
//   imem_req_o/imem_addr_o, imem_ack_i/imem_data_i          memory handshake
//   inst_o, inst_addr_o, valid_o                            to IF/ID
//   flush_o                                                 IF/ID flush
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] BUBBLE_INST = BUBBLE_INST_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                hd_i,
  input  logic                branch_i,
  input  logic [31:0]         branch_addr_i,
  input  logic                jump_i,
  input  logic [JFIELD_W-1:0] jump_field_i,
  input  logic [31:0]         jump_pc4_i,
  output logic                imem_req_o,
  output logic [31:0]         imem_addr_o,
  input  logic                imem_ack_i,
  input  logic [31:0]         imem_data_i,
  output logic [31:0]         inst_o,
  output logic [31:0]         inst_addr_o,
  output logic                valid_o,
  output logic                flush_o
);

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_req_addr;   // address of the request abandoned by a redirect
  logic [31:0] r_buf_inst;
  logic [31:0] r_buf_pc4;

  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_pc4;

  if_next_pc u_next_pc (
    .i_pc          (r_pc),
    .i_hd          (hd_i),
    .i_branch      (branch_i),
    .i_branch_addr (branch_addr_i),
    .i_jump        (jump_i),
    .i_jump_field  (jump_field_i),
    .i_jump_pc4    (jump_pc4_i),
    .o_redirect    (w_redirect),
    .o_target      (w_target),
    .o_pc4         (w_pc4)
  );

  always_comb begin
    imem_req_o  = 1'b0;
    imem_addr_o = r_pc;
    valid_o     = 1'b0;
    inst_o      = BUBBLE_INST;
    inst_addr_o = w_pc4;
    flush_o     = w_redirect & ~rst_i;
    if (!rst_i) begin
      case (r_state)
        ST_REQ: begin
          imem_req_o = 1'b1;
          // Ack data goes straight through so IF/ID captures it this edge.
          if (imem_ack_i && !w_redirect) begin
            valid_o = 1'b1;
            inst_o  = imem_data_i;
          end
        end
        ST_HOLD: begin
          valid_o     = 1'b1;
          inst_o      = r_buf_inst;
          inst_addr_o = r_buf_pc4;
        end
        ST_DISCARD: begin
          // Outstanding request must stay stable until its ack arrives.
          imem_req_o  = 1'b1;
          imem_addr_o = r_req_addr;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_REQ;
      r_pc       <= RESET_PC;
      r_req_addr <= '0;
      r_buf_inst <= '0;
      r_buf_pc4  <= '0;
    end else begin
      case (r_state)
        ST_REQ: begin
          if (imem_ack_i) begin
            if (w_redirect) begin
              r_pc <= w_target;
            end else if (hd_i) begin
              r_buf_inst <= imem_data_i;
              r_buf_pc4  <= w_pc4;
              r_state    <= ST_HOLD;
            end else begin
              r_pc <= w_pc4;
            end
          end else if (w_redirect) begin
            r_pc       <= w_target;
            r_req_addr <= r_pc;
            r_state    <= ST_DISCARD;
          end
        end
        ST_HOLD: begin
          if (w_redirect) begin
            r_pc    <= w_target;
            r_state <= ST_REQ;
          end else if (!hd_i) begin
            r_pc    <= w_pc4;
            r_state <= ST_REQ;
          end
        end
        ST_DISCARD: begin
          if (w_redirect) r_pc <= w_target;
          if (imem_ack_i) r_state <= ST_REQ;
        end
        default: r_state <= ST_REQ;
      endcase
    end
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID register. It owns the program counter and issues requests to a variable-latency instruction memory. Fetched words are presented with their PC+4 to IF/ID. It absorbs load-use stalls from the hazard detection unit and applies branch/jump redirects resolved in ID, generating the IF/ID flush.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- BUBBLE_INST, 32'hFC00_0000, word presented when no valid instruction is available; same NOP encoding IF/ID inserts on flush
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- hd_i  in  1  hazard stall; IF/ID holds, fetch must not advance
- branch_i  in  1  taken branch resolved in ID
- branch_addr_i  in  32  branch target
- jump_i  in  1  jump resolved in ID
- jump_field_i  in  26  instr[25:0] of the jump
- jump_pc4_i  in  32  PC+4 of the jump instruction (IF/ID inst_addr)
- imem_req_o  out  1  memory request, held until ack
- imem_addr_o  out  32  word address, stable while imem_req_o high
- imem_ack_i  in  1  read data valid this cycle, completes request
- imem_data_i  in  32  instruction word
- inst_o  out  32  instruction to IF/ID inst_i
- inst_addr_o  out  32  PC+4 of inst_o to IF/ID inst_addr_i
- valid_o  out  1  inst_o is a real fetched instruction
- flush_o  out  1  to IF/ID flush_i

## Operation
- redirect = (branch_i | jump_i) & ~hd_i; hd_i masks redirects (ID operands not ready). Branch has priority over jump.
- Target: branch → branch_addr_i with bits [1:0] forced to 00; jump → {jump_pc4_i[31:28], jump_field_i, 2'b00}.
- flush_o = redirect, combinational.
- PC increment is PC+4, wrapping modulo 2^32.
- States:
  - REQ: imem_req_o=1, imem_addr_o=pc.
    - ack & ~hd_i & ~redirect → inst_o=imem_data_i, inst_addr_o=pc+4, valid_o=1; pc←pc+4; stay in REQ (back-to-back fetch).
    - ack & hd_i → buffer data and pc+4; go to HOLD.
    - ack & redirect → discard data; pc←target; stay in REQ.
    - ~ack & redirect → pc←target; go to DISCARD.
  - HOLD: imem_req_o=0; inst_o/inst_addr_o=buffer; valid_o=1.
    - ~hd_i & ~redirect → pc←pc+4; go to REQ.
    - redirect → drop buffer; pc←target; go to REQ.
  - DISCARD: imem_req_o=1 with the stale address held in req_addr.
    - ack → data dropped; go to REQ using the current pc.
    - redirect → pc←new target; stay in DISCARD.
- Whenever valid_o=0: inst_o=BUBBLE_INST and inst_addr_o=pc+4.
- Reset: pc=RESET_PC, state=REQ, buffers cleared. During the reset cycle, imem_req_o=0, valid_o=0, flush_o=0, inst_o=BUBBLE_INST. Reset overrides every in-flight state; a pending ack in the reset cycle is ignored.

## Timing
- inst_o/valid_o are combinational from ack or buffer. IF/ID captures them on the same edge the stage advances, so there are zero extra cycles after ack.
- With single-cycle ack, throughput is one instruction per cycle.
- Redirect in cycle N:
  - new target request is visible in cycle N+1, or after the outstanding ack when in DISCARD;
  - the wrong-path word in IF/ID is flushed at the end of cycle N.
- imem_addr_o and imem_req_o must not change while a request is unacknowledged.
- hd_i with no ack pending: request stays up; the ack is buffered into HOLD.

## Structure
- Shared header pipeline_defs.vh holds:
  - BUBBLE_INST;
  - state encodings for REQ, HOLD, DISCARD (2 bits);
  - the opcode-field width constants reused by IF/ID.
- One combinational sub-module, if_next_pc: takes pc, the branch/jump inputs and hd_i, and produces redirect, target and pc+4.

## Test plan
- Reset with RESET_PC=0 and ack every cycle, data k at address 4k → addresses 0,4,8,12 on consecutive cycles; inst_addr_o 4,8,12,16; valid_o=1.
- ack at address 8 while hd_i high for 3 cycles → HOLD; inst_o constant; imem_req_o=0; next request to address 12 only after hd_i falls.
- branch_i with target 0x103 while REQ ack pending → flush_o=1 that cycle; DISCARD until ack; then request to 0x100; discarded word never has valid_o=1.
- jump_i, jump_pc4_i=0x4000_0010, field 0x000_0040 → next request to 0x4000_0100; branch_i in the same cycle wins.
- branch_i while hd_i=1 → ignored, flush_o=0; the same branch after hd_i falls is taken.
- rst_i asserted in DISCARD with ack arriving → next cycle request to RESET_PC; no valid_o.
